// File: rtl/dreg_rr_arbiter_pkg.sv
// rtl/dreg_rr_arbiter_pkg.sv - shared constants and helpers for the round-robin D-register arbiter
package dreg_rr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Bit width needed to hold values 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Increment with explicit wrap so non-power-of-two requester counts work.
    function automatic int next_idx(input int i, input int n);
        return ((i + 1) == n) ? 0 : (i + 1);
    endfunction

endpackage

// File: rtl/dreg_rr_arbiter_pick.sv
// rtl/dreg_rr_arbiter_pick.sv - combinational round-robin search starting at a priority pointer
module rr_pick
    import dreg_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    // Walk ptr, ptr+1, ... with wrap; the first requester found wins.
    always_comb begin
        int j;
        j        = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!o_any && i_req[j]) begin
                o_any       = 1'b1;
                o_idx       = IW'(j);
                o_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dreg_rr_arbiter.sv
// rtl/dreg_rr_arbiter.sv - round-robin write controller for a shared WIDTH-bit register with burst lock
module dreg_rr_arbiter
    import dreg_rr_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    din,
    input  logic                     hold,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         Q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  q_src
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(MAX_LOCK + 1);

    logic [IW-1:0]    r_ptr;
    logic [0:0]       r_st;
    logic [IW-1:0]    r_owner;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic [IW-1:0]    r_q_src;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_owner_cont;
    logic [IW-1:0]    w_win_idx;
    logic             w_grant;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // The locked owner keeps the register until it drops lock/req or exhausts its burst.
    assign w_owner_cont = (r_st == ST_OWN) && req[r_owner] && lock[r_owner]
                          && (r_cnt < CW'(MAX_LOCK));
    assign w_win_idx    = w_owner_cont ? r_owner : w_pick_idx;
    assign w_grant      = rst_n && !hold && (w_owner_cont || w_pick_any);

    // One-hot grant decoded from the winning index; silent in reset or hold.
    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_win_idx] = 1'b1;
        end
    end

    // Shared data register: loads the winner's data, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (w_grant) begin
            r_q <= din[w_win_idx*WIDTH +: WIDTH];
        end
    end

    // Arbitration state: pointer rotation, burst ownership and load reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_st      <= ST_IDLE;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_q_valid <= 1'b0;
            r_q_src   <= '0;
        end else if (w_grant) begin
            r_q_valid <= 1'b1;
            r_q_src   <= w_win_idx;
            r_ptr     <= IW'(next_idx(int'(w_win_idx), NREQ));
            if (w_owner_cont) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (lock[w_win_idx]) begin
                r_st    <= ST_OWN;
                r_owner <= w_win_idx;
                r_cnt   <= CW'(1);
            end else begin
                r_st  <= ST_IDLE;
                r_cnt <= '0;
            end
        end else begin
            r_q_valid <= 1'b0;
            if (!hold) begin
                r_st  <= ST_IDLE;
                r_cnt <= '0;
            end
        end
    end

    assign Q       = r_q;
    assign q_valid = r_q_valid;
    assign q_src   = r_q_src;

endmodule

// File: tb/tb_dreg_rr_arbiter.sv
// tb/tb_dreg_rr_arbiter.sv - self-checking bench for dreg_rr_arbiter
module tb_dreg_rr_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_LOCK = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] din;
    logic                  hold;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      Q;
    logic                  q_valid;
    logic [1:0]            q_src;

    int total;
    int bad;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       hold;
        logic [3:0] exp_gnt;
        logic       exp_qv;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl[25];

    // reference model state
    int         m_ptr;
    bit         m_own;
    int         m_owner;
    int         m_cnt;
    logic [7:0] m_q;
    int         m_src;
    bit         m_qv;
    logic [7:0] m_din[NREQ];

    dreg_rr_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .lock    (lock),
        .din     (din),
        .hold    (hold),
        .gnt     (gnt),
        .Q       (Q),
        .q_valid (q_valid),
        .q_src   (q_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Winner index per the arbitration rules, -1 when nothing is granted.
    function automatic int model_winner(input logic [3:0] r, input logic [3:0] l, input logic h);
        if (h) return -1;
        if (m_own && r[m_owner] && l[m_owner] && m_cnt < MAX_LOCK) return m_owner;
        for (int k = 0; k < NREQ; k++) begin
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic [3:0] l, input logic h);
        int  w;
        bit  cont;
        w    = model_winner(r, l, h);
        cont = !h && m_own && r[m_owner] && l[m_owner] && m_cnt < MAX_LOCK;
        if (w >= 0) begin
            m_q   = m_din[w];
            m_src = w;
            m_qv  = 1'b1;
            m_ptr = (w + 1) % NREQ;
            if (cont) begin
                m_cnt = m_cnt + 1;
            end else if (l[w]) begin
                m_own   = 1'b1;
                m_owner = w;
                m_cnt   = 1;
            end else begin
                m_own = 1'b0;
                m_cnt = 0;
            end
        end else begin
            m_qv = 1'b0;
            if (!h) begin
                m_own = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'hF;
        lock  = 4'h0;
        hold  = 1'b0;
        for (int i = 0; i < NREQ; i++) din[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);

        // rotation
        tbl[0]  = '{4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'hF, 4'h0, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'hF, 4'h0, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 2'd0};
        // sparse with wrap, ptr=1
        tbl[5]  = '{4'h9, 4'h0, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[6]  = '{4'h9, 4'h0, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[7]  = '{4'h9, 4'h0, 1'b0, 4'b1000, 1'b1, 2'd3};
        // locked burst on source 2, forced release after four
        tbl[8]  = '{4'h4, 4'h4, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{4'hF, 4'h4, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{4'hF, 4'h4, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{4'hF, 4'h4, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[12] = '{4'hF, 4'h4, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[13] = '{4'hF, 4'h4, 1'b0, 4'b0001, 1'b1, 2'd0};
        // burst on source 1 interrupted by three hold cycles
        tbl[14] = '{4'hF, 4'h2, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[15] = '{4'hF, 4'h2, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[16] = '{4'hF, 4'h2, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[17] = '{4'hF, 4'h2, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[18] = '{4'hF, 4'h2, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[19] = '{4'hF, 4'h2, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[20] = '{4'hF, 4'h2, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[21] = '{4'hF, 4'h2, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[22] = '{4'hF, 4'h0, 1'b0, 4'b1000, 1'b1, 2'd3};
        // lock without req is ignored
        tbl[23] = '{4'h0, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd3};
        tbl[24] = '{4'h1, 4'h0, 1'b0, 4'b0001, 1'b1, 2'd0};

        // reset state with all sources requesting
        repeat (2) @(negedge clk);
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_q", 32'(Q), 32'h0);
        check("reset_qv", 32'(q_valid), 32'h0);
        check("reset_src", 32'(q_src), 32'h0);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            req   = tbl[i].req;
            lock  = tbl[i].lock;
            hold  = tbl[i].hold;
            rst_n = 1'b1;
            #1;
            if (gnt !== tbl[i].exp_gnt)
                $display("FAIL vec%0d_gnt actual=%b required=%b", i, gnt, tbl[i].exp_gnt);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_qv", i), 32'(q_valid), 32'(tbl[i].exp_qv));
            check($sformatf("vec%0d_src", i), 32'(q_src), 32'(tbl[i].exp_src));
            check($sformatf("vec%0d_q", i), 32'(Q), 32'(8'h10 + 8'(tbl[i].exp_src)));
        end

        // async reset pulse between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q", 32'(Q), 32'h0);
        check("async_qv", 32'(q_valid), 32'h0);
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_src", 32'(q_src), 32'h0);

        // randomized phase against the reference model
        m_ptr = 0; m_own = 0; m_owner = 0; m_cnt = 0; m_q = 8'h0; m_src = 0; m_qv = 0;
        for (int c = 0; c < 400; c++) begin
            int w;
            @(negedge clk);
            req   = 4'($urandom_range(0, 15));
            lock  = 4'($urandom_range(0, 15));
            hold  = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NREQ; i++) begin
                m_din[i] = 8'($urandom);
                din[i*WIDTH +: WIDTH] = m_din[i];
            end
            rst_n = 1'b1;
            #1;
            w = model_winner(req, lock, hold);
            check("rnd_gnt", 32'(gnt), (w < 0) ? 32'h0 : (32'h1 << w));
            @(posedge clk);
            model_edge(req, lock, hold);
            #1;
            check("rnd_qv", 32'(q_valid), 32'(m_qv));
            check("rnd_src", 32'(q_src), 32'(m_src));
            check("rnd_q", 32'(Q), 32'(m_q));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
